// File: rtl/axil_cfg_master.sv
// AXI4-Lite configuration master: single-beat cmd/rsp stream to AXI-Lite.
// One transaction in flight; AXI outputs and status counters are registered.
module axil_cfg_master #(
    parameter int AXIL_ADDR_WIDTH = 40,
    parameter int DATA_WIDTH      = 32,
    parameter int STRB_WIDTH      = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [AXIL_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]      cmd_wdata,
    input  logic [STRB_WIDTH-1:0]      cmd_wstrb,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_write,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic [1:0]                 rsp_resp,
    output logic [AXIL_ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]                 m_axil_awprot,
    output logic                       m_axil_awvalid,
    input  logic                       m_axil_awready,
    output logic [DATA_WIDTH-1:0]      m_axil_wdata,
    output logic [STRB_WIDTH-1:0]      m_axil_wstrb,
    output logic                       m_axil_wvalid,
    input  logic                       m_axil_wready,
    input  logic [1:0]                 m_axil_bresp,
    input  logic                       m_axil_bvalid,
    output logic                       m_axil_bready,
    output logic [AXIL_ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]                 m_axil_arprot,
    output logic                       m_axil_arvalid,
    input  logic                       m_axil_arready,
    input  logic [DATA_WIDTH-1:0]      m_axil_rdata,
    input  logic [1:0]                 m_axil_rresp,
    input  logic                       m_axil_rvalid,
    output logic                       m_axil_rready,
    output logic [CNT_WIDTH-1:0]       wr_count,
    output logic [CNT_WIDTH-1:0]       rd_count,
    output logic [CNT_WIDTH-1:0]       err_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_DATA,
        S_RSP
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                       state_q, state_d;
    logic                         cmd_ready_q, cmd_ready_d;
    logic                         aw_done_q, aw_done_d;
    logic                         w_done_q, w_done_d;
    logic                         awvalid_q, awvalid_d;
    logic                         wvalid_q, wvalid_d;
    logic                         bready_q, bready_d;
    logic                         arvalid_q, arvalid_d;
    logic                         rready_q, rready_d;
    logic [AXIL_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [AXIL_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]        wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]        wstrb_q, wstrb_d;
    logic                         rsp_valid_q, rsp_valid_d;
    logic                         rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0]        rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                   rsp_resp_q, rsp_resp_d;
    logic [CNT_WIDTH-1:0]         wr_cnt_q, wr_cnt_d;
    logic [CNT_WIDTH-1:0]         rd_cnt_q, rd_cnt_d;
    logic [CNT_WIDTH-1:0]         err_cnt_q, err_cnt_d;

    logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_fin, w_fin;

    assign cmd_hs = cmd_valid & cmd_ready_q;
    assign aw_hs  = awvalid_q & m_axil_awready;
    assign w_hs   = wvalid_q & m_axil_wready;
    assign b_hs   = bready_q & m_axil_bvalid;
    assign ar_hs  = arvalid_q & m_axil_arready;
    assign r_hs   = rready_q & m_axil_rvalid;
    assign aw_fin = aw_done_q | aw_hs;
    assign w_fin  = w_done_q | w_hs;

    // Next-state, handshake bookkeeping, response capture and counters
    always_comb begin
        state_d     = state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        err_cnt_d   = err_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_hs) begin
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = S_WR_REQ;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = S_RD_REQ;
                    end
                end
            end
            S_WR_REQ: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_fin && w_fin) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (b_hs) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = m_axil_bresp;
                    wr_cnt_d    = wr_cnt_q + CNT_ONE;
                    if (m_axil_bresp != 2'b00) begin
                        err_cnt_d = err_cnt_q + CNT_ONE;
                    end
                    state_d     = S_RSP;
                end
            end
            S_RD_REQ: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (r_hs) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = m_axil_rdata;
                    rsp_resp_d  = m_axil_rresp;
                    rd_cnt_d    = rd_cnt_q + CNT_ONE;
                    if (m_axil_rresp != 2'b00) begin
                        err_cnt_d = err_cnt_q + CNT_ONE;
                    end
                    state_d     = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        cmd_ready_d = (state_d == S_IDLE);
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_write      = rsp_write_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_resp       = rsp_resp_q;
    assign m_axil_awaddr  = awaddr_q;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;
    assign m_axil_araddr  = araddr_q;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;
    assign wr_count       = wr_cnt_q;
    assign rd_count       = rd_cnt_q;
    assign err_count      = err_cnt_q;

endmodule

// File: tb/tb_axil_cfg_master.sv
// Bench for axil_cfg_master: delay-programmable AXI-Lite slave with memory,
// directed plus random transactions checked against a memory/counter model.
module tb_axil_cfg_master;

    localparam int AW = 40;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_wstrb = '0;
    logic          rsp_ready = 1'b0;
    logic          cmd_ready, rsp_valid, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          awready = 1'b0, wready = 1'b0, arready = 1'b0;
    logic          bvalid = 1'b0, rvalid = 1'b0;
    logic [1:0]    bresp = '0, rresp = '0;
    logic [DW-1:0] rdata = '0;
    logic [CW-1:0] wr_count, rd_count, err_count;

    always #5 clk = ~clk;

    axil_cfg_master #(
        .AXIL_ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .STRB_WIDTH(SW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot),
        .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
        .m_axil_wvalid(wvalid), .m_axil_wready(wready),
        .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
        .m_axil_araddr(araddr), .m_axil_arprot(arprot),
        .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp),
        .m_axil_rvalid(rvalid), .m_axil_rready(rready),
        .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
    );

    // slave configuration
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    bit          r_ovr = 1'b0;
    logic [DW-1:0] r_ovr_data = '0;
    bit          spurious = 1'b0;
    logic [DW-1:0] smem [logic [AW-1:0]];

    // monitor state
    int          cyc = 0;
    bit          t_aw, t_w, t_b, t_ar, t_r;
    int          n_aw, n_w, n_b, n_ar, n_r, n_rsp = 0;
    int          aw_cyc, w_cyc, ar_cyc, aw_hi, w_hi;
    int          viol = 0, early_b = 0;
    logic [AW-1:0] log_awaddr, log_araddr;
    logic [DW-1:0] log_wdata, r_cur = '0;
    logic [SW-1:0] log_wstrb;
    bit          p_awv, p_awhs, p_wv, p_whs, p_arv, p_arhs;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [DW-1:0] p_wdata;
    logic [SW-1:0] p_wstrb;

    // handshake logging, AXI stability rules, slave memory commit
    always @(posedge clk) begin
        if (rst) begin
            {t_aw, t_w, t_b, t_ar, t_r} = '0;
            {p_awv, p_awhs, p_wv, p_whs, p_arv, p_arhs} = '0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                {t_aw, t_w, t_b, t_ar, t_r} = '0;
                {n_aw, n_w, n_b, n_ar, n_r} = '0;
                aw_hi = 0;
                w_hi = 0;
            end
            if (awvalid) aw_hi++;
            if (wvalid) w_hi++;
            if (p_awv && !p_awhs && (!awvalid || awaddr !== p_awaddr)) viol++;
            if (p_wv && !p_whs &&
                (!wvalid || wdata !== p_wdata || wstrb !== p_wstrb)) viol++;
            if (p_arv && !p_arhs && (!arvalid || araddr !== p_araddr)) viol++;
            if (bready && !(t_aw && t_w)) early_b++;
            if (awvalid && awready) begin
                n_aw++; t_aw = 1; aw_cyc = cyc; log_awaddr = awaddr;
            end
            if (wvalid && wready) begin
                n_w++; t_w = 1; w_cyc = cyc;
                log_wdata = wdata; log_wstrb = wstrb;
            end
            if (bvalid && bready) begin
                logic [DW-1:0] cur;
                n_b++; t_b = 1;
                cur = smem.exists(log_awaddr) ? smem[log_awaddr] : '0;
                for (int i = 0; i < SW; i++)
                    if (log_wstrb[i]) cur[8*i +: 8] = log_wdata[8*i +: 8];
                smem[log_awaddr] = cur;
            end
            if (arvalid && arready) begin
                n_ar++; t_ar = 1; ar_cyc = cyc; log_araddr = araddr;
                r_cur = r_ovr ? r_ovr_data :
                        (smem.exists(araddr) ? smem[araddr] : '0);
            end
            if (rvalid && rready) begin
                n_r++; t_r = 1;
            end
            if (rsp_valid && rsp_ready) n_rsp++;
            p_awv = awvalid; p_awhs = awvalid && awready; p_awaddr = awaddr;
            p_wv = wvalid; p_whs = wvalid && wready;
            p_wdata = wdata; p_wstrb = wstrb;
            p_arv = arvalid; p_arhs = arvalid && arready; p_araddr = araddr;
        end
        cyc++;
    end

    // slave responder: each ready/valid appears after its programmed delay
    int aw_w = 0, w_w = 0, ar_w = 0, b_w = 0, r_w = 0;
    always @(negedge clk) begin
        bit bv, rv;
        if (awvalid) begin awready = (aw_w >= aw_dly); aw_w++; end
        else begin awready = 1'b0; aw_w = 0; end
        if (wvalid) begin wready = (w_w >= w_dly); w_w++; end
        else begin wready = 1'b0; w_w = 0; end
        if (arvalid) begin arready = (ar_w >= ar_dly); ar_w++; end
        else begin arready = 1'b0; ar_w = 0; end
        if (t_aw && t_w && !t_b) begin bv = (b_w >= b_dly); b_w++; end
        else begin bv = 1'b0; b_w = 0; end
        if (t_ar && !t_r) begin rv = (r_w >= r_dly); r_w++; end
        else begin rv = 1'b0; r_w = 0; end
        bvalid = bv || spurious;
        rvalid = rv || spurious;
        bresp = bresp_cfg;
        rresp = rresp_cfg;
        rdata = r_cur;
    end

    int n_assert = 0;
    int n_fail = 0;
    int exp_wr = 0, exp_rd = 0, exp_err = 0;
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, ".wr_count"}, wr_count, exp_wr % (1 << CW));
        chk({tag, ".rd_count"}, rd_count, exp_rd % (1 << CW));
        chk({tag, ".err_count"}, err_count, exp_err % (1 << CW));
    endtask

    // issue one command at a negedge, model its result, check everything
    task automatic do_and_check(input string tag, input bit wr,
                                input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic [SW-1:0] s, input int hold);
        int k, lat, tacc, rsp0, exp_lat, mx;
        bit stable;
        logic [DW-1:0] erd, old, mask, rd0;
        logic [1:0] eresp, rr0;
        logic w0;
        rsp0 = n_rsp;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a;
        cmd_wdata = d; cmd_wstrb = s;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        tacc = cyc;
        chk({tag, ".acc_wait"}, k, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_wdata = $urandom;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
        old = ref_mem.exists(a) ? ref_mem[a] : '0;
        if (wr) begin
            for (int b = 0; b < SW; b++) mask[8*b +: 8] = {8{s[b]}};
            ref_mem[a] = (old & ~mask) | (d & mask);
            erd = '0; eresp = bresp_cfg; exp_wr++;
            mx = (aw_dly > w_dly) ? aw_dly : w_dly;
            exp_lat = 3 + mx + b_dly;
        end else begin
            erd = r_ovr ? r_ovr_data : old; eresp = rresp_cfg; exp_rd++;
            exp_lat = 3 + ar_dly + r_dly;
        end
        if (eresp != 2'b00) exp_err++;
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".rsp_write"}, rsp_write, wr);
        chk({tag, ".rsp_rdata"}, rsp_rdata, erd);
        chk({tag, ".rsp_resp"}, rsp_resp, eresp);
        chk_counters(tag);
        if (wr) begin
            chk({tag, ".awaddr"}, log_awaddr, a);
            chk({tag, ".wdata"}, log_wdata, d);
            chk({tag, ".wstrb"}, log_wstrb, s);
            chk({tag, ".aw_cyc"}, aw_cyc - tacc, 1 + aw_dly);
            chk({tag, ".w_cyc"}, w_cyc - tacc, 1 + w_dly);
            chk({tag, ".aw_hi"}, aw_hi, 1 + aw_dly);
            chk({tag, ".w_hi"}, w_hi, 1 + w_dly);
            chk({tag, ".hs_counts"}, {n_aw, n_w, n_b, n_ar},
                {32'd1, 32'd1, 32'd1, 32'd0});
        end else begin
            chk({tag, ".araddr"}, log_araddr, a);
            chk({tag, ".ar_cyc"}, ar_cyc - tacc, 1 + ar_dly);
            chk({tag, ".hs_counts"}, {n_ar, n_r, n_aw, n_w},
                {32'd1, 32'd1, 32'd0, 32'd0});
        end
        rd0 = rsp_rdata; rr0 = rsp_resp; w0 = rsp_write;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== rd0 || rsp_resp !== rr0 ||
                rsp_write !== w0 || cmd_ready !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) chk({tag, ".rsp_hold"}, stable, 1'b1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, ".after_rsp"}, {rsp_valid, cmd_ready}, 2'b01);
        chk({tag, ".one_rsp"}, n_rsp - rsp0, 1);
        chk({tag, ".axi_rules"}, {viol, early_b}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, rsp0;
        bit bad;
        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset.handshakes",
            {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
        chk("reset.addr", {awaddr, araddr}, 0);
        chk("reset.wdata", {wdata, wstrb}, 0);
        chk("reset.rsp", {rsp_write, rsp_rdata, rsp_resp}, 0);
        chk("reset.prot", {awprot, arprot}, 0);
        chk_counters("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("reset.idle_ready", cmd_ready, 1'b1);

        // minimum-latency write
        do_and_check("wr_basic", 1'b1, 40'h10, 32'hDEAD_BEEF, 4'hF, 0);
        // W ready three cycles after AW ready
        w_dly = 3;
        do_and_check("wr_wlate", 1'b1, 40'h18, 32'hCAFE_F00D, 4'h5, 0);
        w_dly = 0;
        // delayed AR and R with fixed read data
        ar_dly = 2; r_dly = 5; r_ovr = 1'b1; r_ovr_data = 32'h1234_5678;
        do_and_check("rd_slow", 1'b0, 40'h14, 32'h0, 4'h0, 0);
        ar_dly = 0; r_dly = 0; r_ovr = 1'b0;
        // error responses, partial-strobe write merged into memory
        bresp_cfg = 2'b10;
        do_and_check("wr_slverr", 1'b1, 40'h10, 32'h1122_3344, 4'h3, 0);
        bresp_cfg = 2'b00; rresp_cfg = 2'b11;
        do_and_check("rd_decerr", 1'b0, 40'h10, 32'h0, 4'h0, 0);
        rresp_cfg = 2'b00;
        // response back-pressure, then back-to-back acceptance
        do_and_check("rd_hold", 1'b0, 40'h18, 32'h0, 4'h0, 10);
        do_and_check("wr_b2b", 1'b1, 40'h1C, 32'hA5A5_5A5A, 4'hF, 0);

        // reset while waiting for bvalid
        b_dly = 30;
        rsp0 = n_rsp;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 40'h20;
        cmd_wdata = 32'hFFFF_FFFF; cmd_wstrb = 4'hF;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (bready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        chk("rst_mid.reach_wr_resp", bready, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        b_dly = 0;
        chk("rst_mid.handshakes",
            {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
        exp_wr = 0; exp_rd = 0; exp_err = 0;
        chk_counters("rst_mid");
        @(negedge clk);
        chk("rst_mid.idle_ready", cmd_ready, 1'b1);
        repeat (3) @(negedge clk);
        chk("rst_mid.no_rsp", {rsp_valid, 31'd0, n_rsp - rsp0}, 0);
        do_and_check("rd_after_rst", 1'b0, 40'h20, 32'h0, 4'h0, 0);

        // stray bvalid/rvalid while idle must be ignored
        spurious = 1'b1;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bready !== 1'b0 || rready !== 1'b0 || rsp_valid !== 1'b0)
                bad = 1'b1;
        end
        spurious = 1'b0;
        @(negedge clk);
        chk("spurious.ignored", bad, 1'b0);
        chk_counters("spurious");

        // random traffic over a small address window; counters wrap
        for (int i = 0; i < 40; i++) begin
            aw_dly = $urandom_range(0, 3);
            w_dly = $urandom_range(0, 3);
            b_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3);
            r_dly = $urandom_range(0, 3);
            bresp_cfg = 2'($urandom_range(0, 3));
            rresp_cfg = 2'($urandom_range(0, 3));
            do_and_check($sformatf("rnd%0d", i), (i % 3) != 0,
                         40'h100 + 40'($urandom_range(0, 7) * 4),
                         $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
